count_sequencer: RTL and testbench
==================================

# count_sequencer

Run/pause/clear controller for the 3-bit display counter chain. It takes debounced button signals, runs a prescaler, and sequences counting through a state machine. It issues one-cycle count-enable strobes and keeps an internal mirror of the count for the seven-segment decoder. It sits between the button chattering eliminators and the counter/decoder pair.

## Interface
- TICK_DIV, 50_000_000, clock cycles per count step; legal range 2 .. 2**TICK_W-1
- TICK_W, 26, prescaler register width; must hold TICK_DIV-1
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start_stop  input  1  debounced run/pause button, active high, synchronous to clk
- clear  input  1  debounced clear button, active high, synchronous to clk
- count_en  output  1  one-cycle strobe; drives the counter enable
- count  output  3  current count value, feeds the seven-segment decoder
- running  output  1  high while in RUN
- done  output  1  high while in DONE (only with COUNT_AUTO_STOP_EN)

## Operation
- Input edge detection:
  - Previous values of start_stop and clear are registered.
  - Only a 0→1 transition is an event, so a level held high acts exactly once.
  - Edge registers reset to 0, so a button held high through reset release produces one event on the first clock.
- States: IDLE, RUN, PAUSE, DONE (DONE exists only with the macro).
- IDLE:
  - count=0, prescaler=0.
  - start_stop event → RUN with prescaler 0.
  - clear event → stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and then wraps to 0.
  - On the wrap edge: count←count+1 and count_en=1 for that one cycle.
  - start_stop event → PAUSE; the prescaler holds its value.
  - clear event → IDLE; count and prescaler go to 0.
- PAUSE:
  - Prescaler and count are frozen.
  - start_stop event → RUN, and the prescaler resumes from its held value.
  - clear event → IDLE.
- DONE: described under Configuration.
- Simultaneous events:
  - clear and start_stop in the same cycle: clear wins and start_stop is discarded.
  - Prescaler wrap and clear in the same cycle: clear wins; no count_en, count→0.
  - Prescaler wrap and start_stop in RUN: the increment and count_en occur, the state goes to PAUSE, and the prescaler holds 0.
- Arithmetic: count is 3-bit modulo-8. The prescaler compare is an equality against TICK_DIV-1.
- Reset, asynchronous and valid at any time including mid-count:
  - state=IDLE, prescaler=0, edge registers=0.
  - Outputs: count=0, count_en=0, running=0, done=0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Event latency: a start_stop or clear input rising at a given edge is acted on at the next edge, 1 cycle.
- First count_en follows exactly TICK_DIV cycles after the edge that enters RUN from IDLE.
- Subsequent count_en strobes are spaced exactly TICK_DIV cycles apart while in RUN.
- Pause/resume preserves phase: total RUN cycles between strobes always equal TICK_DIV.
- count changes on the same edge that count_en rises.
- running is 1 on the edge after entering RUN and 0 on the edge after leaving it.

## Configuration
- COUNT_AUTO_STOP_EN defined:
  - In RUN, the increment from 6 to 7 moves the state to DONE on that edge.
  - count_en is 1 for that step; in the following cycle running=0 and done=1.
  - In DONE, start_stop events are ignored and the prescaler is held at 0.
  - clear event → IDLE with count=0 and done=0.
- COUNT_AUTO_STOP_EN undefined:
  - The DONE state is not built and done is tied to 0.
  - count wraps 7→0 with a normal count_en strobe, and RUN continues.

## Test plan
All scenarios use TICK_DIV=4, TICK_W=3.
- Reset released, start_stop pulsed one cycle → count_en strobes at 4, 8, 12 cycles after the start edge; count reads 1, 2, 3; running=1.
- Run until prescaler=2, pulse start_stop, wait 10 cycles, pulse start_stop again → no strobe while paused; next strobe 2 cycles after resume.
- start_stop and clear asserted in the same cycle during RUN at count=5 → IDLE, count=0, no count_en, running=0.
- start_stop held high for 20 cycles from IDLE → exactly one transition to RUN; counting proceeds normally.
- Count past 7:
  - With COUNT_AUTO_STOP_EN: done=1, count stays 7, and a further start_stop has no effect.
  - Without it: count wraps to 0 and the strobe spacing stays 4.
- reset_n pulled low mid-RUN at count=3, prescaler=2 → all outputs 0 immediately, asynchronously; after release the state is IDLE.

Source files
------------

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Brief    : Run/pause/clear sequencer with prescaled count-enable strobes and
//            a 3-bit count mirror. Optional macro COUNT_AUTO_STOP_EN adds DONE.
// Revision : 1.0 - initial release
// ============================================================================
module count_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic       count_en,
    output logic [2:0] count,
    output logic       running,
    output logic       done
);

    localparam logic [TICK_W-1:0] c_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] c_ONE  = TICK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
`ifdef COUNT_AUTO_STOP_EN
        ,
        S_DONE  = 2'd3
`endif
    } state_t;

    state_t            r_state;
    logic              r_ss_d;
    logic              r_clr_d;
    logic [TICK_W-1:0] r_presc;
    logic [2:0]        r_count;
    logic              r_count_en;
    logic              r_running;
`ifdef COUNT_AUTO_STOP_EN
    logic              r_done;
`endif

    logic w_ss_ev;
    logic w_clr_ev;
    logic w_wrap;

    assign w_ss_ev  = start_stop & ~r_ss_d;
    assign w_clr_ev = clear & ~r_clr_d;
    assign w_wrap   = (r_presc == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ss_d     <= 1'b0;
            r_clr_d    <= 1'b0;
            r_presc    <= '0;
            r_count    <= 3'd0;
            r_count_en <= 1'b0;
            r_running  <= 1'b0;
`ifdef COUNT_AUTO_STOP_EN
            r_done     <= 1'b0;
`endif
        end else begin
            r_ss_d     <= start_stop;
            r_clr_d    <= clear;
            r_count_en <= 1'b0;
            // Clear overrides every other event, including a wrap on this edge.
            if (w_clr_ev) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_count   <= 3'd0;
                r_running <= 1'b0;
`ifdef COUNT_AUTO_STOP_EN
                r_done    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_presc <= '0;
                        r_count <= 3'd0;
                        if (w_ss_ev) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_wrap) begin
                            r_presc    <= '0;
                            r_count    <= r_count + 3'd1;
                            r_count_en <= 1'b1;
                        end else if (!w_ss_ev) begin
                            r_presc <= r_presc + c_ONE;
                        end
`ifdef COUNT_AUTO_STOP_EN
                        if (w_wrap && (r_count == 3'd6)) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else
`endif
                        if (w_ss_ev) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        if (w_ss_ev) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
`ifdef COUNT_AUTO_STOP_EN
                    S_DONE: begin
                        r_presc <= '0;
                    end
`endif
                    default: begin
                        r_state   <= S_IDLE;
                        r_presc   <= '0;
                        r_count   <= 3'd0;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count_en = r_count_en;
    assign count    = r_count;
    assign running  = r_running;
`ifdef COUNT_AUTO_STOP_EN
    assign done     = r_done;
`else
    assign done     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequencer
// Brief    : Directed self-checking bench for count_sequencer (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear      = 1'b0;
    logic       count_en;
    logic [2:0] count;
    logic       running;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    count_sequencer #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_stop (start_stop),
        .clear      (clear),
        .count_en   (count_en),
        .count      (count),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        if ({count, count_en, running, done} !== 6'b0) begin
            $display("FAIL reset_outputs got=%b want=000000", {count, count_en, running, done});
            n_err++;
        end
        n_cmp++;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        if ({count_en, count, running} !== 5'b0) begin
            $display("FAIL reset_idle got=%b want=00000", {count_en, count, running});
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_run_strobes();
        logic       exp_en;
        logic [2:0] exp_cnt;
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        if (running !== 1'b1) begin
            $display("FAIL run_enter running=%b want=1", running);
            n_err++;
        end
        n_cmp++;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            exp_en  = (k % 4 == 0);
            exp_cnt = 3'(k / 4);
            if ({count_en, count, running} !== {exp_en, exp_cnt, 1'b1}) begin
                $display("FAIL run_strobe k=%0d got en=%b cnt=%0d run=%b want en=%b cnt=%0d run=1",
                         k, count_en, count, running, exp_en, exp_cnt);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_pause();
        tick(2);
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        if ({count_en, count, running} !== {1'b0, 3'd3, 1'b0}) begin
            $display("FAIL pause_enter got en=%b cnt=%0d run=%b want en=0 cnt=3 run=0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if ({count_en, count, running} !== {1'b0, 3'd3, 1'b0}) begin
                $display("FAIL pause_hold k=%0d got en=%b cnt=%0d run=%b want en=0 cnt=3 run=0",
                         k, count_en, count, running);
                n_err++;
            end
            n_cmp++;
        end
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        if ({count_en, running} !== 2'b01) begin
            $display("FAIL resume_enter got en=%b run=%b want en=0 run=1", count_en, running);
            n_err++;
        end
        n_cmp++;
        tick(1);
        if (count_en !== 1'b0) begin
            $display("FAIL resume_plus1 count_en=%b want=0", count_en);
            n_err++;
        end
        n_cmp++;
        tick(1);
        if ({count_en, count} !== {1'b1, 3'd4}) begin
            $display("FAIL resume_plus2 got en=%b cnt=%0d want en=1 cnt=4", count_en, count);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_wrap_pause();
        tick(3);
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        if ({count_en, count, running} !== {1'b1, 3'd5, 1'b0}) begin
            $display("FAIL wrap_pause got en=%b cnt=%0d run=%b want en=1 cnt=5 run=0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
        tick(3);
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if ({count_en, count, running} !== {1'b0, 3'd5, 1'b1}) begin
                $display("FAIL wrap_resume k=%0d got en=%b cnt=%0d run=%b want en=0 cnt=5 run=1",
                         k, count_en, count, running);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_clear_priority();
        start_stop = 1'b1;
        clear      = 1'b1;
        tick(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        if ({count_en, count, running} !== 5'b0) begin
            $display("FAIL clear_wins got en=%b cnt=%0d run=%b want en=0 cnt=0 run=0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
        tick(6);
        if ({count_en, count, running} !== 5'b0) begin
            $display("FAIL clear_stays_idle got en=%b cnt=%0d run=%b want en=0 cnt=0 run=0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_held_start();
        logic       exp_en;
        logic [2:0] exp_cnt;
        start_stop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            exp_en  = (k > 0) && (k % 4 == 0);
            exp_cnt = 3'(k / 4);
            if ({count_en, count, running} !== {exp_en, exp_cnt, 1'b1}) begin
                $display("FAIL held_start k=%0d got en=%b cnt=%0d run=%b want en=%b cnt=%0d run=1",
                         k, count_en, count, running, exp_en, exp_cnt);
                n_err++;
            end
            n_cmp++;
        end
        start_stop = 1'b0;
        clear      = 1'b1;
        tick(1);
        clear      = 1'b0;
        if ({count_en, count, running} !== 5'b0) begin
            $display("FAIL wrap_clear got en=%b cnt=%0d run=%b want en=0 cnt=0 run=0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_past_seven();
        logic       exp_en;
        logic [2:0] exp_cnt;
        logic       exp_run;
        logic       exp_done;
        int         last_k;
`ifdef COUNT_AUTO_STOP_EN
        last_k = 28;
`else
        last_k = 36;
`endif
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            tick(1);
            exp_en  = (k % 4 == 0);
            exp_cnt = 3'(k / 4);
`ifdef COUNT_AUTO_STOP_EN
            exp_run  = (k < 28);
            exp_done = (k == 28);
`else
            exp_run  = 1'b1;
            exp_done = 1'b0;
`endif
            if ({count_en, count, running, done} !== {exp_en, exp_cnt, exp_run, exp_done}) begin
                $display("FAIL past_seven k=%0d got en=%b cnt=%0d run=%b done=%b want en=%b cnt=%0d run=%b done=%b",
                         k, count_en, count, running, done, exp_en, exp_cnt, exp_run, exp_done);
                n_err++;
            end
            n_cmp++;
        end
`ifdef COUNT_AUTO_STOP_EN
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        tick(8);
        if ({count_en, count, running, done} !== {1'b0, 3'd7, 1'b0, 1'b1}) begin
            $display("FAIL done_ignores_start got en=%b cnt=%0d run=%b done=%b want en=0 cnt=7 run=0 done=1",
                     count_en, count, running, done);
            n_err++;
        end
        n_cmp++;
`endif
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        if ({count_en, count, running, done} !== 6'b0) begin
            $display("FAIL past_seven_clear got en=%b cnt=%0d run=%b done=%b want all 0",
                     count_en, count, running, done);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        tick(14);
        if ({count, running} !== {3'd3, 1'b1}) begin
            $display("FAIL pre_reset got cnt=%0d run=%b want cnt=3 run=1", count, running);
            n_err++;
        end
        n_cmp++;
        #2 reset_n = 1'b0;
        #1;
        if ({count, count_en, running, done} !== 6'b0) begin
            $display("FAIL async_reset got=%b want=000000", {count, count_en, running, done});
            n_err++;
        end
        n_cmp++;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        if ({count_en, count, running} !== 5'b0) begin
            $display("FAIL post_reset_idle got en=%b cnt=%0d run=%b want all 0",
                     count_en, count, running);
            n_err++;
        end
        n_cmp++;
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            if ({count_en, count} !== {(k == 4), 3'((k == 4) ? 1 : 0)}) begin
                $display("FAIL post_reset_strobe k=%0d got en=%b cnt=%0d want en=%b cnt=%0d",
                         k, count_en, count, (k == 4), ((k == 4) ? 1 : 0));
                n_err++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_run_strobes();
        test_pause();
        test_wrap_pause();
        test_clear_priority();
        test_held_start();
        test_past_seven();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
